// File: rtl/wide_sync_rx_controller.sv
`default_nettype none
// ============================================================================
//  Module   : wide_sync_rx_controller
//  Brief    : Destination-domain sequencer for a wide double-flop synchronizer.
//             Detects a toggle-encoded request, waits a programmable settle
//             time, enables the wide synchronizer for its two-flop depth,
//             captures the word and offers it on a valid/ready interface.
//             Acceptance is returned to the source as a toggle.
//  Revision : 1.0 - initial release
// ============================================================================
module wide_sync_rx_controller #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,               // asynchronous, active-low
    input  logic             req_toggle_async,
    output logic             sync_enable,
    input  logic [WIDTH-1:0] sync_data,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             ack_toggle,
    output logic             busy,
    output logic             overrun
);

    // One-hot state encoding; sync_enable decodes a single state bit.
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_SETTLE  = 5'b00010,
        ST_SAMPLE  = 5'b00100,
        ST_CAPTURE = 5'b01000,
        ST_PRESENT = 5'b10000
    } state_t;

    // Counter reload values. SAMPLE loads 1 so it lasts exactly two cycles,
    // matching the two-flop depth of the wide synchronizer.
    localparam logic [3:0] C_SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [3:0] C_SAMPLE_LOAD = 4'd1;
    localparam bit         C_HAS_SETTLE  = (SETTLE_CYCLES > 0);

    state_t           state_q,    state_d;
    logic [3:0]       cnt_q,      cnt_d;
    logic             req_s1_q,   req_s1_d;
    logic             req_s2_q,   req_s2_d;
    logic             req_seen_q, req_seen_d;
    logic [WIDTH-1:0] data_q,     data_d;
    logic             valid_q,    valid_d;
    logic             ack_q,      ack_d;
    logic             busy_q,     busy_d;
    logic             overrun_q,  overrun_d;
    logic             req_pending;

    // A request is outstanding while the synchronized toggle differs from the last one taken.
    assign req_pending = req_s2_q ^ req_seen_q;

    // Next-state, counter and datapath decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_seen_d = req_seen_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ack_d      = ack_q;
        overrun_d  = overrun_q;
        req_s1_d   = req_toggle_async;
        req_s2_d   = req_s1_q;

        case (state_q)
            ST_IDLE: begin
                if (req_pending) begin
                    req_seen_d = req_s2_q;
                    if (C_HAS_SETTLE) begin
                        state_d = ST_SETTLE;
                        cnt_d   = C_SETTLE_LOAD;
                    end else begin
                        state_d = ST_SAMPLE;
                        cnt_d   = C_SAMPLE_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = C_SAMPLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CAPTURE: begin
                data_d  = sync_data;
                valid_d = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                // data_q is held here; only the handshake moves us on.
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Illegal one-hot pattern: recover to a clean idle.
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // A new toggle while busy is a protocol error; req_seen is left alone
        // so the toggle is still serviced once we are back in IDLE.
        if (req_pending && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, synchronizer and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            req_s1_q   <= 1'b0;
            req_s2_q   <= 1'b0;
            req_seen_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_s1_q   <= req_s1_d;
            req_s2_q   <= req_s2_d;
            req_seen_q <= req_seen_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Enable comes straight from the state register so it cannot glitch.
    assign sync_enable = (state_q == ST_SAMPLE);
    assign data_out    = data_q;
    assign valid       = valid_q;
    assign ack_toggle  = ack_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_sync_rx_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wide_sync_rx_controller
//  Brief    : Directed self-checking bench for wide_sync_rx_controller
//             (one instance with SETTLE_CYCLES=2, one with SETTLE_CYCLES=0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wide_sync_rx_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with settle time 2
    logic       rst, req, ready;
    logic [7:0] sdata;
    logic       se, valid, ack, busy, ovr;
    logic [7:0] dout;

    // Instance with settle time 0
    logic       rst0, req0, ready0;
    logic [7:0] sdata0;
    logic       se0, valid0, ack0, busy0, ovr0;
    logic [7:0] dout0;

    int   n_chk = 0;
    int   n_bad = 0;
    logic exp_ack;
    logic exp_ack0;
    logic [7:0] words [3];

    wide_sync_rx_controller #(.WIDTH(8), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_toggle_async(req), .sync_enable(se),
        .sync_data(sdata), .data_out(dout), .valid(valid), .ready(ready),
        .ack_toggle(ack), .busy(busy), .overrun(ovr)
    );

    wide_sync_rx_controller #(.WIDTH(8), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .req_toggle_async(req0), .sync_enable(se0),
        .sync_data(sdata0), .data_out(dout0), .valid(valid0), .ready(ready0),
        .ack_toggle(ack0), .busy(busy0), .overrun(ovr0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!valid && k < 40) begin
            tick();
            k++;
        end
        check(tag, 32'(valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        rst = 1'b0; req = 1'b0; ready = 1'b0; sdata = 8'h00;
        rst0 = 1'b0; req0 = 1'b0; ready0 = 1'b0; sdata0 = 8'h00;
        exp_ack = 1'b0; exp_ack0 = 1'b0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_se",    32'(se),    32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_ovr",   32'(ovr),   32'd0);
        check("rst_data",  32'(dout),  32'd0);
        rst = 1'b1;
        rst0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_busy", 32'(busy), 32'd0);
        end

        // ---- single word, timing from edge 1 ----
        sdata = 8'hA5;
        req = 1'b1;
        tick(); tick();                               // edges 1,2
        tick(); check("t2_busy_e3", 32'(busy), 32'd1);
                check("t2_se_e3",   32'(se),   32'd0);
        tick(); check("t2_se_e4",   32'(se),   32'd0);
        tick(); check("t2_se_e5",   32'(se),   32'd1);
        tick(); check("t2_se_e6",   32'(se),   32'd1);
        tick(); check("t2_se_e7",   32'(se),   32'd0);
                check("t2_valid_e7", 32'(valid), 32'd0);
        tick(); check("t2_valid_e8", 32'(valid), 32'd1);
                check("t2_data_e8",  32'(dout),  32'h0000_00A5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", 32'(valid), 32'd1);
            check("t2_hold_data",  32'(dout),  32'h0000_00A5);
        end
        ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("t2_acc_valid", 32'(valid), 32'd0);
        check("t2_acc_ack",   32'(ack),   32'(exp_ack));
        ready = 1'b0;

        // ---- back-to-back with ready held high ----
        ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            sdata = words[w];
            req = ~req;
            wait_valid("t3_wait_valid");
            check("t3_data", 32'(dout), 32'(words[w]));
            tick();
            exp_ack = ~exp_ack;
            check("t3_valid_drop", 32'(valid), 32'd0);
            check("t3_ack",        32'(ack),   32'(exp_ack));
        end
        check("t3_ovr", 32'(ovr), 32'd0);
        ready = 1'b0;

        // ---- two toggles before the first acceptance ----
        sdata = 8'h44;
        req = ~req;
        repeat (4) tick();
        req = ~req;
        wait_valid("t4_wait_first");
        check("t4_first_data", 32'(dout), 32'h0000_0044);
        sdata = 8'h55;
        repeat (3) tick();
        check("t4_ovr_set",   32'(ovr),   32'd1);
        check("t4_still_val", 32'(valid), 32'd1);
        check("t4_data_held", 32'(dout),  32'h0000_0044);
        ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("t4_acc1_ack", 32'(ack), 32'(exp_ack));
        ready = 1'b0;
        wait_valid("t4_wait_second");
        check("t4_second_data", 32'(dout), 32'h0000_0055);
        check("t4_ovr_sticky",  32'(ovr),  32'd1);
        ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("t4_acc2_ack", 32'(ack), 32'(exp_ack));
        ready = 1'b0;
        repeat (15) tick();
        check("t4_no_third", 32'(valid), 32'd0);
        check("t4_ovr_end",  32'(ovr),   32'd1);

        // ---- zero settle instance ----
        sdata0 = 8'h3C;
        req0 = 1'b1;
        tick(); tick();
        tick(); check("t5_se_e3",    32'(se0),    32'd1);
        tick(); check("t5_se_e4",    32'(se0),    32'd1);
        tick(); check("t5_se_e5",    32'(se0),    32'd0);
                check("t5_valid_e5", 32'(valid0), 32'd0);
        tick(); check("t5_valid_e6", 32'(valid0), 32'd1);
                check("t5_data_e6",  32'(dout0),  32'h0000_003C);
        ready0 = 1'b1;
        tick();
        exp_ack0 = ~exp_ack0;
        check("t5_ack", 32'(ack0), 32'(exp_ack0));
        ready0 = 1'b0;
        // reset, then release with the request line already high
        rst0 = 1'b0;
        sdata0 = 8'hC3;
        tick();
        exp_ack0 = 1'b0;
        check("t5_rst_ack", 32'(ack0), 32'(exp_ack0));
        rst0 = 1'b1;
        repeat (5) tick();
        check("t5r_valid_e5", 32'(valid0), 32'd0);
        tick();
        check("t5r_valid_e6", 32'(valid0), 32'd1);
        check("t5r_data",     32'(dout0),  32'h0000_00C3);
        ready0 = 1'b1;
        tick();
        exp_ack0 = ~exp_ack0;
        check("t5r_ack", 32'(ack0), 32'(exp_ack0));
        ready0 = 1'b0;
        repeat (15) tick();
        check("t5r_one_word", 32'(valid0), 32'd0);
        check("t5r_idle",     32'(busy0),  32'd0);

        // ---- reset during SAMPLE ----
        sdata = 8'h77;
        req = ~req;
        repeat (5) tick();
        check("t6_in_sample", 32'(se), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_se",    32'(se),    32'd0);
        check("t6_busy",  32'(busy),  32'd0);
        check("t6_valid", 32'(valid), 32'd0);
        check("t6_data",  32'(dout),  32'd0);
        check("t6_ack",   32'(ack),   32'd0);
        check("t6_ovr",   32'(ovr),   32'd0);
        req = 1'b0;
        tick();
        rst = 1'b1;
        exp_ack = 1'b0;
        repeat (3) tick();
        check("t6_quiet", 32'(busy), 32'd0);
        req = 1'b1;
        repeat (7) tick();
        check("t6_valid_e7", 32'(valid), 32'd0);
        tick();
        check("t6_valid_e8", 32'(valid), 32'd1);
        check("t6_data_e8",  32'(dout),  32'h0000_0077);
        ready = 1'b1;
        tick();
        exp_ack = ~exp_ack;
        check("t6_ack_end",   32'(ack),   32'(exp_ack));
        check("t6_valid_end", 32'(valid), 32'd0);
        ready = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
